// File: rtl/weight_fetch_ctrl_pkg.sv
// weight_fetch_ctrl_pkg: shared matrix-unit FSM encoding and 8x8 weight-matrix geometry.
package weight_fetch_ctrl_pkg;

    typedef enum logic [2:0] {S_IDLE, S_ORDER, S_FETCH, S_WAIT_ACK, S_FIN} state_t;

    localparam int NUM_BLOCKS    = 4;
    localparam int ROWS_PER_BLK  = 4;
    localparam int LOWER_ROW_OFF = 4;
    localparam int ROW_W         = $clog2(ROWS_PER_BLK);

    // Blocks 3 and 4 come from the lower four matrix rows.
    function automatic logic [3:0] row_off(input logic [3:0] blk);
        return (blk > 4'(NUM_BLOCKS / 2)) ? 4'(LOWER_ROW_OFF) : 4'd0;
    endfunction

endpackage

// File: rtl/weight_fetch_ctrl_addr_gen.sv
// weight_addr_gen: row/block counters, latched matrix base and registered SRAM row address.
module weight_addr_gen
    import weight_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_load,
    input  logic              i_next_blk,
    input  logic              i_order,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_base,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ROW_W-1:0]  o_row,
    output logic [3:0]        o_blk
);

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [ROW_W-1:0]  r_row;
    logic [3:0]        r_blk;

    // Additions wrap naturally at ADDR_W bits.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_base <= '0;
            r_addr <= '0;
            r_row  <= '0;
            r_blk  <= '0;
        end else begin
            if (i_load) begin
                r_base <= i_base;
                r_blk  <= 4'd1;
            end
            if (i_next_blk)
                r_blk <= r_blk + 4'd1;
            if (i_order) begin
                r_row  <= '0;
                r_addr <= r_base + ADDR_W'(row_off(r_blk));
            end
            if (i_step) begin
                r_row  <= r_row + ROW_W'(1);
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign o_addr = r_addr;
    assign o_row  = r_row;
    assign o_blk  = r_blk;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: sequences four 4x4 weight-block fetches of an 8x8 matrix from SRAM.
module weight_fetch_ctrl
    import weight_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_w_base,
    input  logic              i_block_ack,
    output logic              o_sram_cs,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_change_order,
    output logic              o_en_w_r,
    output logic [3:0]        o_w_order_r,
    output logic              o_block_valid,
    output logic              o_busy,
    output logic              o_done
);

    state_t           r_state;
    logic             r_cs;
    logic             r_chg;
    logic             r_en;
    logic             r_bv;
    logic             r_busy;
    logic             r_done;
    logic             w_load;
    logic             w_ack;
    logic             w_last_blk;
    logic             w_last_row;
    logic [ROW_W-1:0] w_row;
    logic [3:0]       w_blk;

    assign w_load     = (r_state == S_IDLE) && i_start;
    assign w_ack      = (r_state == S_WAIT_ACK) && r_bv && i_block_ack;
    assign w_last_blk = (w_blk == 4'(NUM_BLOCKS));
    assign w_last_row = (w_row == ROW_W'(ROWS_PER_BLK - 1));

    weight_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (w_load),
        .i_next_blk (w_ack && !w_last_blk),
        .i_order    (r_state == S_ORDER),
        .i_step     (r_state == S_FETCH),
        .i_base     (i_w_base),
        .o_addr     (o_sram_addr),
        .o_row      (w_row),
        .o_blk      (w_blk)
    );

    // The first WAIT_ACK cycle still carries the trailing data strobe, so valid rises one cycle later.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_cs    <= 1'b0;
            r_chg   <= 1'b0;
            r_en    <= 1'b0;
            r_bv    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_en   <= r_cs;
            r_chg  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state <= S_ORDER;
                    r_chg   <= 1'b1;
                    r_busy  <= 1'b1;
                end
                S_ORDER: begin
                    r_state <= S_FETCH;
                    r_cs    <= 1'b1;
                end
                S_FETCH: if (w_last_row) begin
                    r_state <= S_WAIT_ACK;
                    r_cs    <= 1'b0;
                end
                S_WAIT_ACK: begin
                    r_bv <= !w_ack;
                    if (w_ack) begin
                        r_state <= w_last_blk ? S_FIN : S_ORDER;
                        r_chg   <= !w_last_blk;
                        r_done  <= w_last_blk;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_sram_cs      = r_cs;
    assign o_change_order = r_chg;
    assign o_en_w_r       = r_en;
    assign o_w_order_r    = w_blk;
    assign o_block_valid  = r_bv;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: doc/weight_fetch_ctrl.md
WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, width of the weight SRAM word address.
REQ-002 CLK  in  1  single clock; all logic on the rising edge.
REQ-003 RSTN  in  1  reset; synchronous and active-low.
REQ-004 START  in  1  single-cycle request to fetch one full 8x8 weight matrix.
REQ-005 W_BASE  in  ADDR_W  SRAM address of matrix row 0; sampled only when START is accepted.
REQ-006 BLOCK_ACK  in  1  downstream systolic array has consumed the current 4x4 weight block.
REQ-007 SRAM_CS  out  1  weight SRAM read enable.
REQ-008 SRAM_ADDR  out  ADDR_W  weight SRAM read address; one 64-bit word holds one matrix row of eight 8-bit weights.
REQ-009 change_order  out  1  single-cycle pulse telling the weight divider to restart block assembly.
REQ-010 EN_W_r  out  1  SRAM-data-valid strobe to the weight divider, one per row word.
REQ-011 w_order_r  out  4  current block number, 1..4.
REQ-012 BLOCK_VALID  out  1  assembled 4x4 block is complete in the weight divider.
REQ-013 BUSY  out  1  high in every state except IDLE.
REQ-014 DONE  out  1  single-cycle pulse after block 4 is acknowledged.

Function
REQ-015 FSM states SHALL be IDLE, ORDER, FETCH, WAIT_ACK and FIN.
REQ-016 IDLE -> ORDER on START=1; W_BASE latched; block counter set to 1.
REQ-017 ORDER: one cycle; change_order=1; w_order_r=block counter; row counter cleared; -> FETCH.
REQ-018 FETCH: four cycles, row k=0..3; SRAM_CS=1; SRAM_ADDR=W_BASE+R+k, with R=0 for blocks 1,2 and R=4 for blocks 3,4; -> WAIT_ACK after k=3.
REQ-019 Address addition SHALL wrap modulo 2^ADDR_W with no overflow flag.
REQ-020 SRAM read latency is one cycle, so EN_W_r SHALL equal SRAM_CS delayed by one register: four consecutive high cycles, each aligned with valid SRAM data.
REQ-021 Block selection: blocks 1,3 use data bits 63:32 (left columns); blocks 2,4 use bits 31:0 (right columns). The weight divider decodes this from w_order_r.
REQ-022 w_order_r SHALL be updated only in ORDER and held stable through FETCH, the trailing EN_W_r cycle and WAIT_ACK.
REQ-023 WAIT_ACK: BLOCK_VALID=1 from the cycle after the last EN_W_r; BLOCK_VALID SHALL NOT assert while EN_W_r=1.
REQ-024 In WAIT_ACK, BLOCK_ACK=1 with block<4 SHALL increment the block counter and move to ORDER; BLOCK_ACK=1 with block=4 SHALL move to FIN.
REQ-025 BLOCK_ACK sampled in the first BLOCK_VALID cycle SHALL be accepted; BLOCK_ACK outside WAIT_ACK SHALL be ignored.
REQ-026 FIN: one cycle; DONE=1; -> IDLE.
REQ-027 START while BUSY=1 SHALL be ignored, and W_BASE SHALL NOT be resampled.
REQ-028 Minimum latency from START to the first BLOCK_VALID SHALL be 7 cycles (IDLE, ORDER, 4xFETCH, trailing EN_W_r).

Reset
REQ-029 With RSTN=0 at a rising edge: state=IDLE; SRAM_CS, change_order, EN_W_r, BLOCK_VALID, BUSY, DONE=0; SRAM_ADDR=0; w_order_r=0; both counters and the latched base=0.
REQ-030 Reset asserted mid-operation SHALL abort at once, with no DONE pulse and no further EN_W_r strobes; a later START restarts from block 1.

Structure
REQ-031 The FSM state encoding, the block count (4), rows per block (4) and the lower-half row offset (4) SHALL live in the shared matrix-unit package.
REQ-032 One sub-module, weight_addr_gen, SHALL hold the row/block counters and compute SRAM_ADDR; the FSM stays in weight_fetch_ctrl.

Verification
REQ-033 W_BASE=0x010, START, BLOCK_ACK tied high -> addresses 0x010-0x013 twice, then 0x014-0x017 twice; w_order_r 1,2,3,4; one DONE.
REQ-034 BLOCK_ACK held low for 20 cycles after block 1 -> BLOCK_VALID held high, SRAM_CS=0, w_order_r=1 stable, no change_order pulse.
REQ-035 W_BASE=0x3FE (ADDR_W=10) -> block 1 addresses 0x3FE, 0x3FF, 0x000, 0x001; block 3 addresses 0x002-0x005.
REQ-036 START pulsed during FETCH with a different W_BASE -> ignored; address sequence unchanged.
REQ-037 RSTN low during block 2 FETCH -> next cycle all outputs at reset values; new START -> change_order with w_order_r=1.
REQ-038 Cycle check: EN_W_r equals SRAM_CS delayed by one cycle throughout; the first BLOCK_VALID is exactly 7 cycles after START.
